// File: rtl/apsq_pkg.sv
// rtl/apsq_pkg.sv - shared types, register map and pad-mode decode for the analog pad sequencer
package apsq_pkg;

    typedef enum logic [1:0] {
        MODE_ANALOG     = 2'b00,
        MODE_DRIVE_LOW  = 2'b01,
        MODE_DRIVE_HIGH = 2'b10,
        MODE_RSVD       = 2'b11
    } pad_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISOLATE,
        ST_SETTLE,
        ST_APPLY
    } seq_state_e;

    localparam logic [3:0] REG_MODE   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_SETTLE = 4'h8;
    localparam logic [3:0] REG_IRQ    = 4'hC;

    // Returns {oeb, out}; the reserved code falls back to the safe analog state.
    function automatic logic [1:0] mode_to_pad(input logic [1:0] mode);
        logic [1:0] pad;
        case (pad_mode_e'(mode))
            MODE_DRIVE_LOW:  pad = 2'b00;
            MODE_DRIVE_HIGH: pad = 2'b01;
            default:         pad = 2'b10;
        endcase
        return pad;
    endfunction

endpackage

// File: rtl/apsq_wb_regs.sv
// rtl/apsq_wb_regs.sv - Wishbone slave, register file, pending slot and interrupt flag
module apsq_wb_regs
    import apsq_pkg::*;
#(
    parameter int          NCH            = 6,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0100,
    parameter int          SETTLE_DEFAULT = 16,
    parameter int          CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stb,
    input  logic              cyc,
    input  logic              we,
    input  logic [3:0]        sel,
    input  logic [31:0]       adr,
    input  logic [31:0]       dat_w,
    output logic              ack,
    output logic [31:0]       dat_r,
    input  logic              seq_active,
    input  logic              busy,
    input  logic              pend_clr,
    input  logic              done_set,
    output logic [2*NCH-1:0]  mode,
    output logic [CNT_W-1:0]  settle,
    output logic              mode_req,
    output logic              pend_valid,
    output logic              irq
);

    localparam int MW = 2 * NCH;

    localparam logic [1:0] SEL_MODE   = REG_MODE[3:2];
    localparam logic [1:0] SEL_STATUS = REG_STATUS[3:2];
    localparam logic [1:0] SEL_SETTLE = REG_SETTLE[3:2];
    localparam logic [1:0] SEL_IRQ    = REG_IRQ[3:2];

    logic              hit;
    logic [1:0]        req_reg;
    logic              req_we;
    logic [3:0]        req_sel;
    logic [31:0]       req_dat;
    logic [31:0]       rdata;
    logic [MW-1:0]     mode_wr;
    logic [CNT_W-1:0]  settle_wr;
    logic              commit_mode;
    logic              commit_settle;
    logic              commit_irq;
    logic              defer;
    logic              overrun;
    logic              irq_en;
    logic              done;
    logic              unused_regs;

    // A new request is only accepted when no ack is outstanding, so ack never repeats back to back.
    assign hit = stb & cyc & (adr[31:4] == BASE_ADDR[31:4]) & ~ack;

    // Writes land on the edge that closes the ack cycle, using the request captured at the hit.
    assign commit_mode   = ack & req_we & (req_reg == SEL_MODE);
    assign commit_settle = ack & req_we & (req_reg == SEL_SETTLE);
    assign commit_irq    = ack & req_we & (req_reg == SEL_IRQ) & req_sel[0];

    // A MODE write is parked in the pending slot whenever a sequence is in flight or already queued.
    assign defer = seq_active | pend_valid;

    assign irq         = done & irq_en;
    assign unused_regs = ^{adr[1:0], req_dat};

    // Read mux; unimplemented bits stay zero.
    always_comb begin
        rdata = '0;
        case (adr[3:2])
            SEL_MODE:   rdata[MW-1:0]    = mode;
            SEL_STATUS: rdata[2:0]       = {overrun, pend_valid, busy};
            SEL_SETTLE: rdata[CNT_W-1:0] = settle;
            SEL_IRQ:    rdata[1:0]       = {done, irq_en};
            default:    rdata = '0;
        endcase
    end

    // Byte-lane merge of write data into MODE and SETTLE.
    always_comb begin
        mode_wr   = mode;
        settle_wr = settle;
        for (int b = 0; b < MW; b++) begin
            if (req_sel[b / 8]) mode_wr[b] = req_dat[b];
        end
        for (int b = 0; b < CNT_W; b++) begin
            if (req_sel[b / 8]) settle_wr[b] = req_dat[b];
        end
    end

    // Bus handshake: capture the request on hit, ack one cycle later with registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack     <= 1'b0;
            dat_r   <= '0;
            req_reg <= '0;
            req_we  <= 1'b0;
            req_sel <= '0;
            req_dat <= '0;
        end else begin
            ack   <= hit;
            dat_r <= (hit && !we) ? rdata : '0;
            if (hit) begin
                req_reg <= adr[3:2];
                req_we  <= we;
                req_sel <= sel;
                req_dat <= dat_w;
            end
        end
    end

    // Register state, pending/overrun bookkeeping and the DONE flag (set beats W1C).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode       <= '0;
            settle     <= CNT_W'(SETTLE_DEFAULT);
            irq_en     <= 1'b0;
            done       <= 1'b0;
            pend_valid <= 1'b0;
            overrun    <= 1'b0;
            mode_req   <= 1'b0;
        end else begin
            mode_req <= commit_mode & ~defer;
            if (commit_mode)   mode   <= mode_wr;
            if (commit_settle) settle <= settle_wr;
            if (commit_irq)    irq_en <= req_dat[0];
            done <= done_set | (done & ~(commit_irq & req_dat[1]));
            if (commit_mode && defer) begin
                pend_valid <= 1'b1;
                if (pend_valid && !pend_clr) overrun <= 1'b1;
            end else if (pend_clr) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/analog_pad_sequencer.sv
// rtl/analog_pad_sequencer.sv - break-before-make sequencer driving analog-capable pad controls
module analog_pad_sequencer
    import apsq_pkg::*;
#(
    parameter int          NCH            = 6,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0100,
    parameter int          SETTLE_DEFAULT = 16,
    parameter int          CNT_W          = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic [NCH-1:0]  io_out,
    output logic [NCH-1:0]  io_oeb,
    output logic            busy,
    output logic            irq
);

    localparam int MW = 2 * NCH;

    seq_state_e        state;
    seq_state_e        state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [MW-1:0]     applied;
    logic [MW-1:0]     tgt;
    logic [MW-1:0]     mode;
    logic [CNT_W-1:0]  settle;
    logic [NCH-1:0]    oeb_q;
    logic [NCH-1:0]    out_q;
    logic              start;
    logic              apply_now;
    logic              pend_clr;
    logic              mode_req;
    logic              pend_valid;
    logic              seq_active;

    assign seq_active = (state != ST_IDLE);
    // A queued target keeps busy asserted through the APPLY cycle so back-to-back sequences look continuous.
    assign busy   = (state == ST_ISOLATE) || (state == ST_SETTLE) ||
                    ((state == ST_APPLY) && pend_valid && (mode != applied));
    assign io_oeb = oeb_q;
    assign io_out = out_q;

    apsq_wb_regs #(
        .NCH            (NCH),
        .BASE_ADDR      (BASE_ADDR),
        .SETTLE_DEFAULT (SETTLE_DEFAULT),
        .CNT_W          (CNT_W)
    ) u_regs (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .stb        (wbs_stb_i),
        .cyc        (wbs_cyc_i),
        .we         (wbs_we_i),
        .sel        (wbs_sel_i),
        .adr        (wbs_adr_i),
        .dat_w      (wbs_dat_i),
        .ack        (wbs_ack_o),
        .dat_r      (wbs_dat_o),
        .seq_active (seq_active),
        .busy       (busy),
        .pend_clr   (pend_clr),
        .done_set   (apply_now),
        .mode       (mode),
        .settle     (settle),
        .mode_req   (mode_req),
        .pend_valid (pend_valid),
        .irq        (irq)
    );

    // Next-state logic: start on a fresh or queued target that differs from what the pads carry.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        start     = 1'b0;
        apply_now = 1'b0;
        pend_clr  = 1'b0;
        case (state)
            ST_IDLE, ST_APPLY: begin
                state_nx = ST_IDLE;
                pend_clr = pend_valid;
                if ((mode_req || pend_valid) && (mode != applied)) begin
                    start    = 1'b1;
                    state_nx = ST_ISOLATE;
                end
            end
            ST_ISOLATE: begin
                if (settle == '0) begin
                    apply_now = 1'b1;
                    state_nx  = ST_APPLY;
                end else begin
                    cnt_nx   = settle - CNT_W'(1);
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    apply_now = 1'b1;
                    state_nx  = ST_APPLY;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, counter and pad registers; changed pads are released before any new value is driven.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            applied <= '0;
            tgt     <= '0;
            oeb_q   <= '1;
            out_q   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (start) begin
                tgt <= mode;
                for (int i = 0; i < NCH; i++) begin
                    if (mode[2*i +: 2] != applied[2*i +: 2]) begin
                        oeb_q[i] <= 1'b1;
                        out_q[i] <= 1'b0;
                    end
                end
            end
            if (apply_now) begin
                applied <= tgt;
                for (int i = 0; i < NCH; i++) begin
                    {oeb_q[i], out_q[i]} <= mode_to_pad(tgt[2*i +: 2]);
                end
            end
        end
    end

endmodule

// File: tb/tb_analog_pad_sequencer.sv
// tb/tb_analog_pad_sequencer.sv - directed self-checking bench for analog_pad_sequencer
module tb_analog_pad_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat = 32'h0;
    logic        ack;
    logic [31:0] dat_o;
    logic [5:0]  io_out;
    logic [5:0]  io_oeb;
    logic        busy;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [11:0] mode;
        logic [7:0]  settle;
        logic [5:0]  iso_oeb;
        logic [5:0]  iso_out;
        logic [5:0]  fin_oeb;
        logic [5:0]  fin_out;
    } vec_t;

    vec_t vecs [5];

    analog_pad_sequencer #(
        .NCH            (6),
        .BASE_ADDR      (BASE),
        .SETTLE_DEFAULT (16),
        .CNT_W          (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .busy      (busy),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
        int n;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = 4'hF;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack !== 1'b1 && n < 8);
        rd = dat_o;
        if (ack !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_ack_timeout addr %0h: got no ack, expected ack", a);
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        wb_access(1'b1, a, d, rd);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
        wb_access(1'b0, a, 32'h0, rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [5:0]  prev_oeb;
        logic [5:0]  prev_out;
        int          cyc_n;
        int          first_006;
        int          first_00a;
        int          saw_009;
        int          acks;

        vecs[0] = '{12'h006, 8'd4, 6'h3F, 6'h00, 6'h3C, 6'h01};
        vecs[1] = '{12'h005, 8'd4, 6'h3D, 6'h00, 6'h3C, 6'h00};
        vecs[2] = '{12'h805, 8'd0, 6'h3C, 6'h00, 6'h1C, 6'h20};
        vecs[3] = '{12'h8C6, 8'd1, 6'h1D, 6'h20, 6'h1C, 6'h21};
        vecs[4] = '{12'h000, 8'd2, 6'h3F, 6'h00, 6'h3F, 6'h00};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_oeb",  32'(io_oeb), 32'h3F);
        check("rst_out",  32'(io_out), 32'h0);
        check("rst_busy", 32'(busy),   32'h0);
        check("rst_irq",  32'(irq),    32'h0);
        check("rst_ack",  32'(ack),    32'h0);
        check("rst_dat",  dat_o,       32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        wb_read(BASE + 32'h0, rd); check("rst_mode",   rd, 32'h0);
        wb_read(BASE + 32'h4, rd); check("rst_status", rd, 32'h0);
        wb_read(BASE + 32'h8, rd); check("rst_settle", rd, 32'd16);
        wb_read(BASE + 32'hC, rd); check("rst_irqreg", rd, 32'h0);

        // Table-driven mode sequences
        prev_oeb = 6'h3F;
        prev_out = 6'h00;
        for (int v = 0; v < 5; v++) begin
            wb_write(BASE + 32'h8, 32'(vecs[v].settle));
            wb_write(BASE + 32'h0, 32'(vecs[v].mode));
            check($sformatf("v%0d_e0_oeb", v), 32'(io_oeb), 32'(prev_oeb));
            check($sformatf("v%0d_e0_out", v), 32'(io_out), 32'(prev_out));
            for (int k = 1; k <= int'(vecs[v].settle) + 1; k++) begin
                @(posedge clk); #1;
                check($sformatf("v%0d_iso%0d_oeb", v, k), 32'(io_oeb), 32'(vecs[v].iso_oeb));
                check($sformatf("v%0d_iso%0d_out", v, k), 32'(io_out), 32'(vecs[v].iso_out));
                check($sformatf("v%0d_iso%0d_busy", v, k), 32'(busy), 32'h1);
            end
            @(posedge clk); #1;
            check($sformatf("v%0d_fin_oeb", v), 32'(io_oeb), 32'(vecs[v].fin_oeb));
            check($sformatf("v%0d_fin_out", v), 32'(io_out), 32'(vecs[v].fin_out));
            check($sformatf("v%0d_fin_busy", v), 32'(busy), 32'h0);
            wb_read(BASE + 32'hC, rd);
            check($sformatf("v%0d_done", v), rd, 32'h2);
            wb_write(BASE + 32'hC, 32'h2);
            prev_oeb = vecs[v].fin_oeb;
            prev_out = vecs[v].fin_out;
        end

        // Writing the applied mode starts nothing
        wb_write(BASE + 32'h0, 32'h000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("same_mode_busy", 32'(busy), 32'h0);
        end
        wb_read(BASE + 32'hC, rd); check("same_mode_nodone", rd, 32'h0);

        // Two writes during a running sequence: overrun, 0x009 never reaches the pads
        wb_write(BASE + 32'h8, 32'd4);
        wb_write(BASE + 32'h0, 32'h006);
        wb_write(BASE + 32'h0, 32'h009);
        wb_write(BASE + 32'h0, 32'h00A);
        first_006 = -1;
        first_00a = -1;
        saw_009   = 0;
        for (cyc_n = 1; cyc_n <= 40; cyc_n++) begin
            @(posedge clk); #1;
            if (io_oeb == 6'h3C && io_out == 6'h02) saw_009 = 1;
            if (first_006 < 0 && io_oeb == 6'h3C && io_out == 6'h01) first_006 = cyc_n;
            if (io_oeb == 6'h3C && io_out == 6'h03 && busy == 1'b0) begin
                first_00a = cyc_n;
                break;
            end
        end
        check("ovr_no_009", 32'(saw_009), 32'h0);
        check("ovr_006_seen", 32'(first_006 > 0), 32'h1);
        check("ovr_00a_seen", 32'(first_00a > 0), 32'h1);
        check("ovr_gap", 32'(first_00a - first_006), 32'd6);
        wb_read(BASE + 32'h4, rd); check("ovr_status", rd, 32'h4);
        wb_read(BASE + 32'h0, rd); check("ovr_mode",   rd, 32'h00A);

        // Interrupt: enable, W1C, set on APPLY, W1C coinciding with APPLY
        wb_write(BASE + 32'hC, 32'h1);
        check("irq_pending_done", 32'(irq), 32'h1);
        wb_write(BASE + 32'hC, 32'h3);
        check("irq_w1c_drop", 32'(irq), 32'h0);
        wb_write(BASE + 32'h0, 32'h000);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("irq_low_busy", 32'(irq), 32'h0);
        end
        wb_write(BASE + 32'hC, 32'h3);
        check("irq_w1c_vs_apply", 32'(irq), 32'h1);
        check("irq_apply_oeb", 32'(io_oeb), 32'h3F);
        wb_read(BASE + 32'hC, rd); check("irq_reg", rd, 32'h3);
        wb_write(BASE + 32'hC, 32'h3);
        check("irq_w1c_final", 32'(irq), 32'h0);

        // Asynchronous reset during SETTLE with a pending write
        wb_write(BASE + 32'h8, 32'd0);
        wb_write(BASE + 32'h0, 32'h800);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_oeb", 32'(io_oeb), 32'h1F);
        check("pre_rst_out", 32'(io_out), 32'h20);
        wb_write(BASE + 32'h8, 32'd4);
        wb_write(BASE + 32'h0, 32'h801);
        wb_write(BASE + 32'h0, 32'h802);
        check("pre_rst_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst_oeb",  32'(io_oeb), 32'h3F);
        check("arst_out",  32'(io_out), 32'h0);
        check("arst_busy", 32'(busy),   32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        wb_read(BASE + 32'h4, rd); check("arst_status", rd, 32'h0);
        wb_read(BASE + 32'h8, rd); check("arst_settle", rd, 32'd16);
        repeat (3) @(posedge clk);
        #1;
        check("arst_no_restart", 32'(busy), 32'h0);

        // Access just past the window: no ack, no register effect
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h10; dat = 32'hFFF; sel = 4'hF;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        check("oow_no_ack", 32'(acks), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("oow_oeb", 32'(io_oeb), 32'h3F);
        wb_read(BASE + 32'h0, rd); check("oow_mode", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
